window_pingpong_loader: RTL

Parametrised double-buffered window loader for the convolution accelerator's module controller. It streams memory words into the fill buffer while the other, complete buffer is presented to the PE bus. The two buffers swap roles under a valid/ready handshake on both sides. It also captures PE results returned on the bus and counts them.

---
 rtl/window_pingpong_loader_if.sv | 30 +++
 rtl/window_pingpong_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/window_pingpong_loader_if.sv
// Bundle of the memory-in, window-out and PE-result signals of the window loader.
// master drives the loader's inputs; slave is the loader itself.
interface window_pingpong_loader_if #(
  parameter int unsigned MEM_WIDTH    = 24,
  parameter int unsigned WIN_W        = 72,
  parameter int unsigned RESULT_WIDTH = 18
);
  logic                    flush;
  logic                    mem_valid;
  logic [MEM_WIDTH-1:0]    mem_data;
  logic                    mem_ready;
  logic                    win_valid;
  logic [WIN_W-1:0]        win_data;
  logic                    win_ready;
  logic                    fill_sel;
  logic                    res_valid;
  logic [RESULT_WIDTH-1:0] res_data;
  logic [RESULT_WIDTH-1:0] stored_result;
  logic [15:0]             res_count;

  modport master (
    output flush, mem_valid, mem_data, win_ready, res_valid, res_data,
    input  mem_ready, win_valid, win_data, fill_sel, stored_result, res_count
  );

  modport slave (
    input  flush, mem_valid, mem_data, win_ready, res_valid, res_data,
    output mem_ready, win_valid, win_data, fill_sel, stored_result, res_count
  );
endinterface

// File: rtl/window_pingpong_loader.sv
// Double-buffered window loader: one buffer fills from memory while the other,
// complete one is presented to the PE bus; also captures and counts PE results.
module window_pingpong_loader #(
  parameter int unsigned MEM_WIDTH    = 24,
  parameter int unsigned ELEM_WIDTH   = 8,
  parameter int unsigned WINDOW_ELEMS = 9,
  parameter int unsigned RESULT_WIDTH = 18
) (
  input logic                  clk,
  input logic                  rst,
  window_pingpong_loader_if.slave bus
);
  localparam int unsigned WIN_W = ELEM_WIDTH * WINDOW_ELEMS;
  localparam int unsigned WORDS = WIN_W / MEM_WIDTH;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  if ((WIN_W % MEM_WIDTH) != 0 || WORDS == 0) begin : g_bad_width
    $error("window_pingpong_loader: window width must be a whole number of memory words");
  end

  logic [WIN_W-1:0]        buf_a;
  logic [WIN_W-1:0]        buf_b;
  logic [WIN_W-1:0]        fill_buf;
  logic [WIN_W-1:0]        fill_shift;
  logic [CNT_W-1:0]        word_cnt;
  logic                    fill_full;
  logic                    drain_full;
  logic                    fill_sel;
  logic [WIN_W-1:0]        win_data;
  logic [RESULT_WIDTH-1:0] stored_result;
  logic [15:0]             res_count;
  logic                    accept;
  logic                    handshake;
  logic                    swap;

  // Words enter at the top so the first word of a window ends in the LSBs.
  always_comb begin
    fill_buf   = fill_sel ? buf_b : buf_a;
    fill_shift = WIN_W'({bus.mem_data, fill_buf} >> MEM_WIDTH);
    accept     = bus.mem_valid && !fill_full;
    handshake  = drain_full && bus.win_ready;
    swap       = fill_full && (!drain_full || handshake);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_a      <= '0;
      buf_b      <= '0;
      word_cnt   <= '0;
      fill_full  <= 1'b0;
      drain_full <= 1'b0;
      fill_sel   <= 1'b0;
      win_data   <= '0;
    end else if (bus.flush) begin
      buf_a      <= '0;
      buf_b      <= '0;
      word_cnt   <= '0;
      fill_full  <= 1'b0;
      drain_full <= 1'b0;
      fill_sel   <= 1'b0;
      win_data   <= '0;
    end else begin
      if (accept) begin
        if (fill_sel) buf_b <= fill_shift;
        else          buf_a <= fill_shift;
        if (word_cnt == LAST_WORD) begin
          word_cnt  <= '0;
          fill_full <= 1'b1;
        end else begin
          word_cnt  <= word_cnt + CNT_W'(1);
        end
      end
      // Accept and swap are exclusive: accept needs !fill_full, swap needs fill_full.
      if (swap) begin
        fill_sel   <= !fill_sel;
        fill_full  <= 1'b0;
        drain_full <= 1'b1;
        win_data   <= fill_buf;
      end else if (handshake) begin
        drain_full <= 1'b0;
      end
    end
  end

  // Result capture runs independently of the window path and of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored_result <= '0;
      res_count     <= '0;
    end else if (bus.res_valid) begin
      stored_result <= bus.res_data;
      res_count     <= res_count + 16'd1;
    end
  end

  assign bus.mem_ready     = !fill_full;
  assign bus.win_valid     = drain_full;
  assign bus.win_data      = win_data;
  assign bus.fill_sel      = fill_sel;
  assign bus.stored_result = stored_result;
  assign bus.res_count     = res_count;
endmodule
